// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the memory_controller CPU interface.
// One transfer in flight at a time; a per-transfer timeout ends transfers the
// controller never answers, and those are acked with an error flag.
module mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  output logic                  p0_err,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic                  p1_err,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [ADDR_WIDTH-1:0] mc_addr,
  output logic [DATA_WIDTH-1:0] mc_write_data,
  output logic                  mc_read_en,
  output logic                  mc_write_en,
  input  logic                  mc_ready,
  input  logic [DATA_WIDTH-1:0] mc_read_data
);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } xfer_t;

  typedef enum logic [1:0] {IDLE, BUSY, CAPTURE, DONE} state_t;

  // Last BUSY cycle before the timeout fires (counter is 8 bits wide).
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state, state_nxt;
  xfer_t                 xfer_q, grant_xfer;
  logic                  sel_q, last_grant_q, err_q;
  logic                  any_req, grant_sel, timeout_hit;
  logic [7:0]            cnt_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  // Round-robin pick: a tie goes to the port that did not win last time.
  always_comb begin
    any_req   = p0_req | p1_req;
    grant_sel = 1'b0;
    if (p0_req && p1_req) grant_sel = ~last_grant_q;
    else                  grant_sel = p1_req;
    grant_xfer = grant_sel ? {p1_we, p1_addr, p1_wdata} : {p0_we, p0_addr, p0_wdata};
  end

  // A ready in the final counted cycle still wins over the timeout.
  assign timeout_hit = (cnt_q == CNT_LAST) && !mc_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY: begin
        if (mc_ready)         state_nxt = xfer_q.we ? DONE : CAPTURE;
        else if (timeout_hit) state_nxt = DONE;
      end
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transfer latch, timeout counter, read-data capture and grant history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      xfer_q       <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            sel_q  <= grant_sel;
            xfer_q <= grant_xfer;
            err_q  <= 1'b0;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 8'd1;
          if (timeout_hit) begin
            err_q <= 1'b1;
            // A timed-out read returns zero to its port.
            if (!xfer_q.we) begin
              if (sel_q) rdata1_q <= '0;
              else       rdata0_q <= '0;
            end
          end
        end
        CAPTURE: begin
          if (sel_q) rdata1_q <= mc_read_data;
          else       rdata0_q <= mc_read_data;
        end
        DONE: begin
          last_grant_q <= sel_q;
          cnt_q        <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mc_addr       = xfer_q.addr;
  assign mc_write_data = xfer_q.wdata;
  assign mc_write_en   = (state == BUSY) &&  xfer_q.we;
  assign mc_read_en    = (state == BUSY) && !xfer_q.we;

  assign p0_ack   = (state == DONE) && !sel_q;
  assign p1_ack   = (state == DONE) &&  sel_q;
  assign p0_err   = p0_ack && err_q;
  assign p1_err   = p1_ack && err_q;
  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int TO = 15;

  logic        clk, reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p1_addr;
  logic [7:0]  p0_wdata, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [7:0]  p0_rdata, p1_rdata;
  logic [15:0] mc_addr;
  logic [7:0]  mc_write_data, mc_read_data;
  logic        mc_read_en, mc_write_en, mc_ready, mdl_rdy, force_rdy;

  int errors, checks;

  mem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mc_addr(mc_addr), .mc_write_data(mc_write_data),
    .mc_read_en(mc_read_en), .mc_write_en(mc_write_en),
    .mc_ready(mc_ready), .mc_read_data(mc_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mc_ready = mdl_rdy | force_rdy;

  // Controller model: window 0x1000-0x10FF; writes ready one cycle after the
  // enable is seen, reads ready two cycles after, data registered after ready.
  bit [7:0] cmem [256];
  int cst;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cst <= 0; mdl_rdy <= 1'b0; mc_read_data <= 8'h00;
    end else begin
      case (cst)
        0: begin
          mdl_rdy <= 1'b0;
          if (mc_addr[15:8] == 8'h10) begin
            if (mc_write_en) begin
              cmem[mc_addr[7:0]] <= mc_write_data; mdl_rdy <= 1'b1; cst <= 1;
            end else if (mc_read_en) cst <= 2;
          end
        end
        1: begin mdl_rdy <= 1'b0; cst <= 0; end
        2: begin mdl_rdy <= 1'b1; cst <= 3; end
        3: begin mdl_rdy <= 1'b0; mc_read_data <= cmem[mc_addr[7:0]]; cst <= 0; end
        default: cst <= 0;
      endcase
    end
  end

  // Reference model state: memory contents, per-port rdata, last winner.
  bit [7:0]   refmem [256];
  logic [7:0] rdq [2];
  logic       last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one granted transfer, from the transfer rules alone.
  task automatic predict(input logic p, input logic we, input logic [15:0] a,
                         input logic [7:0] wd, output int lat, output logic e,
                         output logic [7:0] rd);
    if (a[15:8] != 8'h10) begin
      lat = TO + 1; e = 1'b1;
      if (!we) rdq[p] = 8'h00;
    end else if (we) begin
      lat = 3; e = 1'b0; refmem[a[7:0]] = wd;
    end else begin
      lat = 5; e = 1'b0; rdq[p] = refmem[a[7:0]];
    end
    rd = rdq[p];
    last = p;
  endtask

  task automatic setp(input int p, input logic r, input logic we,
                      input logic [15:0] a, input logic [7:0] d);
    if (p == 0) begin p0_req = r; p0_we = we; p0_addr = a; p0_wdata = d; end
    else        begin p1_req = r; p1_we = we; p1_addr = a; p1_wdata = d; end
  endtask

  int         lat, wen;
  logic       ap, ae;
  logic [7:0] ard;
  logic [15:0] en_addr;

  // Wait (bounded) for the next ack; optionally force mc_ready in one cycle.
  task automatic wait_ack(input int force_at);
    lat = 0; wen = 0; ap = 1'b0; ae = 1'b0; ard = 8'h00; en_addr = 16'h0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      chk("one_ack", 32'(p0_ack & p1_ack), 0);
      if (mc_write_en) begin wen++; en_addr = mc_addr; end
      if (p0_ack || p1_ack) begin
        lat = n; ap = p1_ack;
        ae  = p1_ack ? p1_err : p0_err;
        ard = p1_ack ? p1_rdata : p0_rdata;
        break;
      end
      force_rdy = (n == force_at);
    end
    force_rdy = 1'b0;
  endtask

  task automatic go(input string tag, input logic ep, input int el, input logic ee,
                    input logic [7:0] erd, input int force_at);
    wait_ack(force_at);
    chk({tag, "_lat"},   32'(lat), 32'(el));
    chk({tag, "_port"},  32'(ap),  32'(ep));
    chk({tag, "_err"},   32'(ae),  32'(ee));
    chk({tag, "_rdata"}, 32'(ard), 32'(erd));
  endtask

  task automatic idle();
    p0_req = 1'b0; p1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  int         el, acks, r;
  logic       ee, w;
  logic [7:0] erd;
  logic       rwe [2];
  logic [15:0] raddr [2];
  logic [7:0] rwd [2];

  initial begin
    errors = 0; checks = 0; force_rdy = 1'b0; reset = 1'b1;
    setp(0, 1'b0, 1'b0, 16'h0, 8'h0); setp(1, 1'b0, 1'b0, 16'h0, 8'h0);
    last = 1'b1; rdq[0] = 8'h00; rdq[1] = 8'h00;
    repeat (2) @(posedge clk); #1;
    chk("rst_ack_err", 32'({p0_ack, p1_ack, p0_err, p1_err}), 0);
    chk("rst_rdata",   32'({p0_rdata, p1_rdata}), 0);
    chk("rst_en",      32'({mc_read_en, mc_write_en}), 0);
    chk("rst_mc_bus",  32'({mc_addr, mc_write_data}), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Port 0 write 0xA5 to 0x1004.
    setp(0, 1'b1, 1'b1, 16'h1004, 8'hA5);
    predict(1'b0, 1'b1, 16'h1004, 8'hA5, el, ee, erd);
    go("wr0", 1'b0, el, ee, erd, 0);
    chk("wr0_wen_cycles", 32'(wen), 2);
    chk("wr0_mc_addr", 32'(en_addr), 32'h1004);
    idle();

    // Port 1 reads it back.
    setp(1, 1'b1, 1'b0, 16'h1004, 8'h00);
    predict(1'b1, 1'b0, 16'h1004, 8'h00, el, ee, erd);
    go("rd1", 1'b1, el, ee, erd, 0);
    idle();

    // Both held for four transfers: alternate 0,1,0,1.
    setp(0, 1'b1, 1'b1, 16'h1010, 8'h11);
    setp(1, 1'b1, 1'b1, 16'h1011, 8'h22);
    for (int k = 0; k < 4; k++) begin
      w = ~last;
      predict(w, 1'b1, w ? 16'h1011 : 16'h1010, w ? 8'h22 : 8'h11, el, ee, erd);
      go("rr", w, el + (k > 0 ? 1 : 0), ee, erd, 0);
      chk("rr_order", 32'(ap), 32'(k % 2));
    end
    idle();

    // Out-of-window read times out; port 1 then served normally.
    setp(0, 1'b1, 1'b0, 16'h0004, 8'h00);
    predict(1'b0, 1'b0, 16'h0004, 8'h00, el, ee, erd);
    go("tmo", 1'b0, el, ee, erd, 0);
    idle();
    setp(1, 1'b1, 1'b0, 16'h1004, 8'h00);
    predict(1'b1, 1'b0, 16'h1004, 8'h00, el, ee, erd);
    go("after_tmo", 1'b1, el, ee, erd, 0);
    idle();

    // Ready arrives in the last counted cycle: write completes without error.
    setp(0, 1'b1, 1'b1, 16'h0008, 8'h5A);
    go("rdy_at_limit", 1'b0, TO + 1, 1'b0, rdq[0], TO);
    last = 1'b0;
    idle();

    // Reset during BUSY of a read.
    setp(0, 1'b1, 1'b0, 16'h1004, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy_rd_en", 32'(mc_read_en), 1);
    reset = 1'b1; #1;
    chk("rst_mid_en",  32'({mc_read_en, mc_write_en}), 0);
    chk("rst_mid_ack", 32'({p0_ack, p1_ack}), 0);
    p0_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    last = 1'b1; rdq[0] = 8'h00; rdq[1] = 8'h00;
    chk("rst_mid_rdata1", 32'(p1_rdata), 32'(rdq[1]));
    acks = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (p0_ack || p1_ack) acks++;
    end
    chk("rst_no_ack", 32'(acks), 0);
    setp(0, 1'b1, 1'b1, 16'h1020, 8'h33);
    setp(1, 1'b1, 1'b1, 16'h1021, 8'h44);
    predict(1'b0, 1'b1, 16'h1020, 8'h33, el, ee, erd);
    go("post_rst", 1'b0, el, ee, erd, 0);
    p0_req = 1'b0;
    predict(1'b1, 1'b1, 16'h1021, 8'h44, el, ee, erd);
    go("post_rst_b", 1'b1, el + 1, ee, erd, 0);
    idle();

    // Random traffic; a losing port keeps its request until served.
    repeat (40) begin
      r = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        rwe[p]   = 1'($urandom_range(0, 1));
        raddr[p] = 16'h1000 | 16'($urandom_range(0, 15));
        if (!rwe[p] && $urandom_range(0, 7) == 0) raddr[p] = 16'h2000 | 16'($urandom_range(0, 255));
        rwd[p]   = 8'($urandom);
        setp(p, 1'(r >> p), rwe[p], raddr[p], rwd[p]);
      end
      w = (r == 3) ? ~last : (r == 2);
      predict(w, rwe[w], raddr[w], rwd[w], el, ee, erd);
      go("rnd", w, el, ee, erd, 0);
      if (r == 3) begin
        setp(int'(w), 1'b0, rwe[w], raddr[w], rwd[w]);
        w = ~w;
        predict(w, rwe[w], raddr[w], rwd[w], el, ee, erd);
        go("rnd_pend", w, el + 1, ee, erd, 0);
      end
      idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
